um245r_ctrl: RTL
================

# um245r_ctrl

Synchronous controller that sequences the asynchronous UM245R USB FIFO interface (`D`, `WR`, `_RD`, `_TXE`, `_RXF`) on behalf of the CPU side. It exposes two valid/ready byte streams, TX and RX. It arbitrates the shared bidirectional `D` bus between pending transmits and available received bytes, and generates strobes with parameterised pulse, setup and recovery widths in clock cycles. It sits between the CPU's memory-mapped UART port logic and the `um245r` device (model in simulation).

## Interface
- `RD_CYC`, default 6: cycles `_RD` is held low. Data is sampled on the last of these cycles. Minimum 2.
- `WR_SETUP_CYC`, default 2: cycles `D` is driven with `WR`=0 before `WR` rises. Minimum 1.
- `WR_CYC`, default 6: cycles `WR` is held high. Minimum 1.
- `GAP_CYC`, default 6: recovery cycles after any transfer before the next arbitration. Minimum 3; smaller values are a static elaboration error.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `tx_data` in 8: byte to transmit.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: the TX holding register is empty.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: `rx_data` is valid.
- `rx_ready` in 1: the consumer takes `rx_data`.
- `D` inout 8: tristate UART data bus.
- `WR` out 1: UART write strobe. The byte is written on the falling edge.
- `_RD` out 1: UART read enable, active low.
- `_TXE` in 1: asynchronous; low means the UART can accept a byte.
- `_RXF` in 1: asynchronous; low means the UART holds a byte.

## Operation
- `_TXE` and `_RXF` each pass through a 2-flop synchroniser. Arbitration uses only the synchronised values.
- TX holding register (1 byte):
  - Loads on `tx_valid & tx_ready`.
  - `tx_ready` is the inverse of the register's full flag.
  - The register clears when the WR falling edge is issued.
- RX storage: a single holding register by default; see Configuration.
- `rx_req` = synchronised `_RXF` low and RX storage not full.
- `tx_req` = TX holding register full and synchronised `_TXE` low.
- FSM states:
  - **IDLE**: arbitration takes place only here.
    - Only `rx_req` → RD.
    - Only `tx_req` → WSETUP.
    - Both: grant the side not granted last (round-robin bit `last_tx`). After reset, RX wins the first tie.
  - **RD**: `_RD`=0 for `RD_CYC` cycles. On the final cycle `D` is captured into RX storage. Then `_RD`=1 and → GAP.
  - **WSETUP**: `D` driven with the TX byte and `WR`=0 for `WR_SETUP_CYC` cycles, then → WHIGH.
  - **WHIGH**: `D` driven, `WR`=1 for `WR_CYC` cycles. Then `WR`=0 while `D` stays driven, TX register clears, → WHOLD.
  - **WHOLD**: `D` driven for 1 cycle, then released. → GAP.
  - **GAP**: all strobes inactive for `GAP_CYC` cycles so synchronised flags reflect the post-transfer UART state. Then → IDLE.
- `D` is driven only in WSETUP, WHIGH and WHOLD; it is hi-Z in every other state.
- `_RD`=0 and D-drive are never simultaneous; this is a design invariant.
- Cycle counter: one shared down-counter, width clog2 of the largest parameter + 1.

## Timing
- Reset values:
  - `_RD`=1, `WR`=0, `D` hi-Z.
  - `tx_ready`=0 during reset, 1 on the first cycle after.
  - `rx_valid`=0, `rx_data`=0.
  - FSM in IDLE; `last_tx`=1; synchroniser flops=1 (inactive).
- RX latency: `_RXF` falling → `_RD` low takes 3 cycles (2 sync + 1 arbitration), if IDLE and storage free. The captured byte gives `rx_valid`=1 on the cycle after capture.
- TX latency: accept → `WR` rise takes 1 + `WR_SETUP_CYC` cycles, if IDLE and `_TXE` synchronised low.
- Back-to-back throughput per byte: RD + GAP, or `WR_SETUP_CYC` + `WR_CYC` + 1 + `GAP_CYC`.
- Simultaneous accept and clear:
  - A TX accept in the same cycle as the TX register clears is not possible, because `tx_ready` is registered.
  - An RX pop in the same cycle as an RX capture is legal with the FIFO; the single register requires not full, so it cannot occur.
- Flags changing during a transfer are ignored until IDLE.
- Reset mid-operation:
  - At the reset edge, `_RD`→1, `WR`→0 and `D`→hi-Z together.
  - Reset during WHIGH may commit the byte to the UART. That byte and the held RX byte are discarded.

## Configuration
- `UM245R_CTRL_RX_FIFO_EN`:
  - Defined: RX storage is a 4-entry FIFO (first-word-fall-through, 2-bit pointers plus wrap bit). `rx_req` requires count < 4.
  - Undefined: a 1-byte holding register. `rx_req` requires `rx_valid`=0.
- Handshake and timing are otherwise identical.

## Structure
- Package `um245r_ctrl_pkg`: FSM state enum (IDLE, RD, WSETUP, WHIGH, WHOLD, GAP), default timing constants, and RX FIFO depth constant (4).
- Sub-module `um245r_ctrl_rx_fifo`: 8-bit, depth 4, first-word-fall-through. Instantiated only under `UM245R_CTRL_RX_FIFO_EN`.

## Test plan
- **Reset:** assert `reset` 3 cycles with the model idle → `_RD`=1, `WR`=0, `D`=zzzzzzzz, `rx_valid`=0. `tx_ready`=1 one cycle after release.
- **Read sequence:** model control file supplies "a","b","c"; `rx_ready`=1 → `rx_data` yields 8'h61, 8'h62, 8'h63 in order. Each `_RD` low pulse is exactly 6 cycles, and no new read occurs while `_RXF` stays high.
- **Write:** push 8'h21 → `D`=8'h21 from WSETUP through WHOLD. The model logs "!" on the `WR` fall. `WR` is high for exactly 6 cycles and `tx_ready` returns to 1.
- **Arbitration:** `_RXF` low and TX byte 8'h41 pending simultaneously after reset → read granted first, write next. Alternation continues for 4 transfers.
- **Backpressure:** `rx_ready`=0 with 5 bytes available → exactly 1 read without the macro, or 4 reads with it. Then `_RD` stays high until a pop.
- **Reset mid-read:** assert `reset` in the third RD cycle → `_RD`=1 on the next edge, `rx_valid` stays 0, and normal reads resume after release.

Source files
------------

// File: rtl/um245r_ctrl_pkg.sv
// Shared types and timing defaults for the UM245R USB FIFO controller.
package um245r_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSETUP,
        WHIGH,
        WHOLD,
        GAP
    } state_e;

    localparam int DEF_RD_CYC       = 6;
    localparam int DEF_WR_SETUP_CYC = 2;
    localparam int DEF_WR_CYC       = 6;
    localparam int DEF_GAP_CYC      = 6;

    localparam int RX_FIFO_DEPTH = 4;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/um245r_ctrl_rx_fifo.sv
// 8-bit, 4-deep first-word-fall-through FIFO holding received bytes.
// Used by um245r_ctrl only when UM245R_CTRL_RX_FIFO_EN is defined.
module um245r_ctrl_rx_fifo
    import um245r_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] pop_data_o,
    output logic       valid_o,
    output logic       full_o
);
    localparam int AW = $clog2(RX_FIFO_DEPTH);

    logic [7:0]  mem_q [RX_FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty;

    // Extra pointer bit tells full from empty when the index bits match.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i && !empty)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are live, and unreset RAM maps to cheaper cells.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign valid_o    = !empty;
    assign pop_data_o = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/um245r_ctrl.sv
// Sequences the asynchronous UM245R FIFO bus for a TX/RX valid/ready byte pair.
// Define UM245R_CTRL_RX_FIFO_EN for a 4-entry RX FIFO instead of a 1-byte register.
module um245r_ctrl
    import um245r_ctrl_pkg::*;
#(
    parameter int RD_CYC       = DEF_RD_CYC,
    parameter int WR_SETUP_CYC = DEF_WR_SETUP_CYC,
    parameter int WR_CYC       = DEF_WR_CYC,
    parameter int GAP_CYC      = DEF_GAP_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    inout  wire  [7:0] D,
    output logic       WR,
    output logic       _RD,
    input  logic       _TXE,
    input  logic       _RXF
);
    localparam int CNT_W = $clog2(max4(RD_CYC, WR_SETUP_CYC, WR_CYC, GAP_CYC)) + 1;

    if (RD_CYC < 2 || WR_SETUP_CYC < 1 || WR_CYC < 1 || GAP_CYC < 3) begin : g_param_err
        $error("um245r_ctrl: timing parameter below its minimum");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_tx_q, last_tx_d;
    logic [1:0]       txe_sync_q, rxf_sync_q;
    logic             tx_full_q, tx_full_d, tx_ready_q;
    logic [7:0]       tx_data_q;
    logic             rx_room, rx_req, tx_req, rx_capture, tx_clear, d_oe;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            txe_sync_q <= 2'b11;
            rxf_sync_q <= 2'b11;
        end else begin
            txe_sync_q <= {txe_sync_q[0], _TXE};
            rxf_sync_q <= {rxf_sync_q[0], _RXF};
        end
    end

    assign rx_req     = !rxf_sync_q[1] && rx_room;
    assign tx_req     = tx_full_q && !txe_sync_q[1];
    assign rx_capture = (state_q == RD) && (cnt_q == '0);
    assign tx_clear   = (state_q == WHIGH) && (cnt_q == '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tx_full_d = tx_full_q;
        if (tx_clear)                      tx_full_d = 1'b0;
        else if (tx_valid && tx_ready_q)   tx_full_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_full_q  <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_full_q  <= tx_full_d;
            tx_ready_q <= !tx_full_d;
            if (tx_valid && tx_ready_q) tx_data_q <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_tx_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_tx_q <= last_tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        last_tx_d = last_tx_q;
        unique case (state_q)
            IDLE: begin
                // Ties go to whichever side was not served last.
                if (rx_req && (!tx_req || last_tx_q)) begin
                    state_d   = RD;
                    cnt_d     = CNT_W'(RD_CYC - 1);
                    last_tx_d = 1'b0;
                end else if (tx_req) begin
                    state_d   = WSETUP;
                    cnt_d     = CNT_W'(WR_SETUP_CYC - 1);
                    last_tx_d = 1'b1;
                end
            end
            RD: if (cnt_q == '0) begin
                state_d = GAP;
                cnt_d   = CNT_W'(GAP_CYC - 1);
            end
            WSETUP: if (cnt_q == '0) begin
                state_d = WHIGH;
                cnt_d   = CNT_W'(WR_CYC - 1);
            end
            WHIGH: if (cnt_q == '0) state_d = WHOLD;
            WHOLD: begin
                state_d = GAP;
                cnt_d   = CNT_W'(GAP_CYC - 1);
            end
            GAP: if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        _RD  = 1'b1;
        WR   = 1'b0;
        d_oe = 1'b0;
        unique case (state_q)
            RD:     _RD  = 1'b0;
            WSETUP: d_oe = 1'b1;
            WHIGH: begin
                d_oe = 1'b1;
                WR   = 1'b1;
            end
            WHOLD:  d_oe = 1'b1;
            default: ;
        endcase
    end

    assign D        = d_oe ? tx_data_q : 8'hzz;
    assign tx_ready = tx_ready_q;

`ifdef UM245R_CTRL_RX_FIFO_EN
    logic rx_full;

    um245r_ctrl_rx_fifo u_rx_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (rx_capture),
        .push_data_i (D),
        .pop_i       (rx_valid && rx_ready),
        .pop_data_o  (rx_data),
        .valid_o     (rx_valid),
        .full_o      (rx_full)
    );

    assign rx_room = !rx_full;
`else
    logic       rx_valid_q;
    logic [7:0] rx_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else if (rx_capture) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= D;
        end else if (rx_ready) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_room  = !rx_valid_q;
`endif

endmodule
